// File: rtl/fp_to_int.sv
// fp_to_int: float32 to int32 converter with valid/ready handshakes.
// A one-bit-per-cycle shifter aligns the significand, then one rounding cycle.
module fp_to_int (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic        rnd_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_out,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_mag;
    logic        r_guard;
    logic        r_sticky;
    logic        r_left;
    logic        r_sign;
    logic        r_rne;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_inexact;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_frac_nz;
    logic        w_rnd_up;
    logic [31:0] w_mag_rnd;

    assign w_sign    = a_in[31];
    assign w_exp     = a_in[30:23];
    assign w_frac    = a_in[22:0];
    assign w_frac_nz = |w_frac;

    assign w_rnd_up  = r_rne && r_guard && (r_sticky || r_mag[0]);
    assign w_mag_rnd = r_mag + {31'b0, w_rnd_up};

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign result_out = r_result;
    assign invalid    = r_invalid;
    assign inexact    = r_inexact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mag     <= 32'd0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            r_rne     <= 1'b0;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
            r_invalid <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign   <= w_sign;
                        r_rne    <= rnd_sel;
                        r_mag    <= 32'd0;
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_left   <= 1'b0;
                        r_cnt    <= 5'd0;
                        if (w_exp == 8'hFF && w_frac_nz) begin
                            r_result  <= 32'h7FFF_FFFF;
                            r_invalid <= 1'b1;
                            r_inexact <= 1'b0;
                            r_state   <= DONE;
                        end else if (w_exp >= 8'd158) begin
                            r_result  <= w_sign ? 32'h8000_0000
                                                : 32'h7FFF_FFFF;
                            r_invalid <= !(w_sign && w_exp == 8'd158
                                           && !w_frac_nz);
                            r_inexact <= 1'b0;
                            r_state   <= DONE;
                        end else if (w_exp == 8'd0) begin
                            r_result  <= 32'd0;
                            r_invalid <= 1'b0;
                            r_inexact <= w_frac_nz;
                            r_state   <= DONE;
                        end else if (w_exp <= 8'd125) begin
                            r_sticky <= 1'b1;
                            r_state  <= ROUND;
                        end else if (w_exp == 8'd126) begin
                            r_guard  <= 1'b1;
                            r_sticky <= w_frac_nz;
                            r_state  <= ROUND;
                        end else begin
                            r_mag <= {8'b0, 1'b1, w_frac};
                            // 150-E and E-150 taken mod 32; both fit in 5 bits
                            if (w_exp < 8'd150) begin
                                r_cnt   <= 5'd22 - w_exp[4:0];
                                r_state <= SHIFT;
                            end else if (w_exp > 8'd150) begin
                                r_cnt   <= w_exp[4:0] - 5'd22;
                                r_left  <= 1'b1;
                                r_state <= SHIFT;
                            end else begin
                                r_state <= ROUND;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_result  <= r_sign ? (32'd0 - w_mag_rnd) : w_mag_rnd;
                    r_invalid <= 1'b0;
                    r_inexact <= r_guard | r_sticky;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Sequential IEEE-754 single-precision to signed 32-bit integer converter. It decodes a packed float32 word and produces a two's-complement int32 with IEEE-style invalid and inexact flags. It sits downstream of the float multiply/divide datapath and hands float results to integer consumers. It uses a valid/ready handshake on both sides and an iterative one-bit-per-cycle shifter.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  converter idle and able to accept.
- a_in  input  32  float32 operand, sampled on accept.
- rnd_sel  input  1  rounding mode, sampled on accept:
  - 0 = truncate toward zero.
  - 1 = round to nearest, ties to even.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result_out  output  32  signed int32 result.
- invalid  output  1  NaN, infinity or out-of-range operand.
- inexact  output  1  nonzero fraction discarded (valid only when invalid=0).

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- in_ready is 1 only in IDLE. The operand is accepted on an edge where in_valid && in_ready.
- Decode on accept:
  - s = a_in[31]; E = a_in[30:23]; F = a_in[22:0]; e = E - 127 (signed).
- Specials, IDLE goes straight to DONE:
  - E=255 with F≠0 (NaN) → 0x7FFFFFFF, invalid=1.
  - s=0 and e≥31 (includes +inf) → 0x7FFFFFFF, invalid=1.
  - s=1 and e≥31, except exactly −2^31 → 0x80000000, invalid=1.
  - s=1, e=31, F=0 → 0x80000000, invalid=0, inexact=0.
  - E=0 (zero or denormal) → 0x00000000; inexact=1 iff F≠0.
  - e≤−2 (normal) → magnitude 0, guard 0, sticky 1; goes to ROUND.
  - e=−1 → magnitude 0, guard 1, sticky = (F≠0); goes to ROUND.
- Normal path, 0≤e≤30:
  - mag is 32 bits, loaded with {8'b0, 1'b1, F}. Guard and sticky start at 0.
  - If e<23: right-shift N = 23−e times. Each cycle the guard takes the old mag[0], and sticky ORs in the old guard.
  - If e≥23: left-shift N = e−23 times. The result is exact.
  - If N=0, IDLE goes directly to ROUND.
- ROUND, one cycle:
  - If rnd_sel=1 and guard && (sticky || mag[0]), increment mag.
  - inexact = guard || sticky.
  - If s=1, result = −mag (two's complement); otherwise result = mag. A zero magnitude gives 0x00000000 (no negative zero).
  - Rounding cannot exceed 2^31−1 for e≤30. No post-round saturation is required.
- DONE:
  - out_valid=1. result_out, invalid and inexact are held stable.
  - On out_valid && out_ready, go to IDLE.

## Timing
- Reset (async, rst_n low): state IDLE, in_ready=1, out_valid=0, result_out=0, invalid=0, inexact=0.
- Reset mid-operation aborts; the pending result is discarded.
- Latency, counted in edges from the accept edge to the edge that sets out_valid:
  - specials: 1.
  - normal path: N+2, where N is the shift count.
- Worst case is 25 edges (e=0). e=23 gives 2.
- While in SHIFT, ROUND or DONE, in_valid is ignored and in_ready=0.
- out_ready may be held low indefinitely; outputs must not change meanwhile.
- The DONE→IDLE edge deasserts out_valid. in_ready rises in the following cycle, so throughput is at most one result per latency+1 cycles.
- Reset released mid-cycle: the first accept can occur on the first edge with rst_n high.

## Test plan
- a_in=0x3F800000 (1.0), rnd_sel=0 → result 0x00000001, flags 0, out_valid 25 edges after accept.
- Rounding, each → listed result with inexact=1:
  - 0x40200000 (2.5), rnd_sel=1 → 2.
  - 0x40600000 (3.5), rnd_sel=1 → 4.
  - 0xBFC00000 (−1.5), rnd_sel=1 → 0xFFFFFFFE.
  - 0xBFC00000, rnd_sel=0 → 0xFFFFFFFF.
  - 0x3F000000 (0.5), rnd_sel=1 → 0.
- Range and specials:
  - 0xCF000000 → 0x80000000 with invalid=0.
  - 0x4F000000 → 0x7FFFFFFF with invalid=1.
  - 0x7FC00000 → 0x7FFFFFFF with invalid=1, latency 1.
  - 0xFF800000 → 0x80000000 with invalid=1.
  - 0x00000001 → 0 with inexact=1.
- Left-shift path:
  - 0x4B000001 → 0x00800001, latency 2.
  - 0x4EFFFFFF → 0x7FFFFF80, latency 9, flags 0.
- Backpressure:
  - Complete a conversion with out_ready low for 5 cycles. Outputs stay stable, in_ready=0, and a new in_valid is ignored.
  - Raise out_ready: out_valid drops on the next edge, and in_ready=1 the cycle after.
- Accept 1.0, then pull rst_n low during SHIFT → all outputs reset immediately. After release, convert 0x40400000 (3.0) → 0x00000003.
